// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the sequential word comparator.
//   state_t      : FSM state encoding (IDLE / SCAN / DONE)
//   CMP_*        : 2-bit slice verdict constants
//   nslice()     : number of 2-bit slices for a given operand width
//   idx_width()  : width of a slice index (never less than 1)
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  function automatic int nslice(input int width);
    return width / 2;
  endfunction

  function automatic int idx_width(input int width);
    return (width / 2 <= 1) ? 1 : $clog2(width / 2);
  endfunction

endpackage

// File: rtl/seq_word_comparator_if.sv
// Bus bundle of the sequential word comparator.
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid && ready are both high. The start channel carries a_in/b_in; the
// result channel carries gt/eq/lt/diff_idx, which stay stable while
// res_valid is high and res_ready is low.
//   master : the operand producer / result consumer
//   slave  : the comparator
// Signals: start_valid, start_ready, a_in, b_in, res_valid, res_ready,
//          gt, eq, lt, diff_idx, busy.
interface seq_word_comparator_if #(
  parameter int WIDTH = 8
);
  import seq_cmp_pkg::*;

  localparam int IDXW = idx_width(WIDTH);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             res_valid;
  logic             res_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [IDXW-1:0]  diff_idx;
  logic             busy;

  modport master (
    output start_valid, a_in, b_in, res_ready,
    input  start_ready, res_valid, gt, eq, lt, diff_idx, busy
  );

  modport slave (
    input  start_valid, a_in, b_in, res_ready,
    output start_ready, res_valid, gt, eq, lt, diff_idx, busy
  );

endinterface

// File: rtl/seq_word_comparator_cmp2_slice.sv
// cmp2_slice: combinational unsigned compare of two 2-bit slices.
// Ports:
//   a_i, b_i   : 2-bit slices
//   verdict_o  : CMP_GT / CMP_EQ / CMP_LT
module cmp2_slice
  import seq_cmp_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [1:0] verdict_o
);

  always_comb begin
    verdict_o = CMP_EQ;
    if (a_i > b_i) begin
      verdict_o = CMP_GT;
    end else if (a_i < b_i) begin
      verdict_o = CMP_LT;
    end
  end

endmodule

// File: rtl/seq_word_comparator.sv
// seq_word_comparator: sequential unsigned magnitude comparator. Accepts an
// operand pair, scans it MSB-first one 2-bit slice per clock, and presents
// a word-level gt/eq/lt verdict plus the index of the most significant
// differing slice.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : start/result handshakes, operands, verdict, busy
//   dbg_state_o  : current FSM state
// Build option: define EARLY_EXIT_EN to leave SCAN as soon as the first
// differing slice is found. Verdicts are the same either way.
module seq_word_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_word_comparator_if.slave  bus,
  output state_t                dbg_state_o
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = idx_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx_q;
  logic             decided_q;
  // Running verdict built during SCAN; copied to the outputs only on DONE entry.
  logic             vgt_q, vlt_q;
  logic [IDXW-1:0]  vdiff_q;
  logic             gt_q, eq_q, lt_q;
  logic [IDXW-1:0]  diff_idx_q;

  logic [IDXW:0]    base;
  logic [1:0]       a_sl, b_sl, verdict;
  logic             diff_now, last_slice, accept, scan_done, release_res;

  assign base = {idx_q, 1'b0};
  assign a_sl = a_q[base +: 2];
  assign b_sl = b_q[base +: 2];

  cmp2_slice u_slice (
    .a_i       (a_sl),
    .b_i       (b_sl),
    .verdict_o (verdict)
  );

  // First difference only: once decided, later slices are ignored.
  assign diff_now    = (state_q == ST_SCAN) && !decided_q && (verdict != CMP_EQ);
  assign last_slice  = (idx_q == '0);
  assign accept      = (state_q == ST_IDLE) && bus.start_valid;
  assign release_res = (state_q == ST_DONE) && bus.res_ready;
`ifdef EARLY_EXIT_EN
  assign scan_done   = (state_q == ST_SCAN) && (last_slice || diff_now);
`else
  assign scan_done   = (state_q == ST_SCAN) && last_slice;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_SCAN;
      ST_SCAN: if (scan_done)   state_d = ST_DONE;
      ST_DONE: if (release_res) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.start_ready = (state_q == ST_IDLE);
    bus.res_valid   = (state_q == ST_DONE);
    bus.busy        = (state_q != ST_IDLE);
  end

  // Operands, slice index and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      decided_q  <= 1'b0;
      vgt_q      <= 1'b0;
      vlt_q      <= 1'b0;
      vdiff_q    <= '0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      if (accept) begin
        a_q       <= bus.a_in;
        b_q       <= bus.b_in;
        idx_q     <= IDXW'(NSLICE - 1);
        decided_q <= 1'b0;
        vgt_q     <= 1'b0;
        vlt_q     <= 1'b0;
        vdiff_q   <= '0;
      end
      if (state_q == ST_SCAN) begin
        if (diff_now) begin
          decided_q <= 1'b1;
          vgt_q     <= (verdict == CMP_GT);
          vlt_q     <= (verdict == CMP_LT);
          vdiff_q   <= idx_q;
        end
        if (!last_slice) begin
          idx_q <= idx_q - 1'b1;
        end
      end
      // The slice examined in the final SCAN cycle can itself be the first
      // difference, so fold the live verdict in when publishing.
      if (scan_done) begin
        gt_q       <= diff_now ? (verdict == CMP_GT) : vgt_q;
        lt_q       <= diff_now ? (verdict == CMP_LT) : vlt_q;
        eq_q       <= !(decided_q || diff_now);
        diff_idx_q <= diff_now ? idx_q : vdiff_q;
      end
      // Verdict flags read as zero whenever the block is idle.
      if (release_res) begin
        gt_q <= 1'b0;
        eq_q <= 1'b0;
        lt_q <= 1'b0;
      end
    end
  end

  assign bus.gt       = gt_q;
  assign bus.eq       = eq_q;
  assign bus.lt       = lt_q;
  assign bus.diff_idx = diff_idx_q;
  assign dbg_state_o  = state_q;

endmodule
